// File: rtl/ase_pcie_ss_pkg.sv
// Shared types and width helpers for the ASE PCIe SS multi-channel bridge.
package ase_pcie_ss_pkg;

  localparam int DEF_TDATA_WIDTH = 512;
  localparam int DEF_TUSER_WIDTH = 10;
  localparam int DEF_TKEEP_W     = DEF_TDATA_WIDTH / 8;

  // Packed beat layout as carried on every stream port: {tlast,tuser,tkeep,tdata}
  typedef struct packed {
    logic                       tlast;
    logic [DEF_TUSER_WIDTH-1:0] tuser;
    logic [DEF_TKEEP_W-1:0]     tkeep;
    logic [DEF_TDATA_WIDTH-1:0] tdata;
  } t_ase_pcie_ss_beat;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  function automatic int beat_w(input int tdata_width, input int tuser_width);
    return 1 + tdata_width + tuser_width + tdata_width / 8;
  endfunction

  function automatic int ch_w(input int num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/ase_pcie_ss_multi_chan_bridge_beat_fifo.sv
// Per-channel synchronous beat FIFO: RAM array with a registered head word,
// one-cycle push-to-visible latency, no same-cycle fall-through.
module ase_pcie_ss_beat_fifo #(
  parameter int DEPTH  = 8,
  parameter int BEAT_W = 8
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push_i,
  input  logic [BEAT_W-1:0]      wdata_i,
  input  logic                   pop_i,
  output logic [BEAT_W-1:0]      rdata_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [BEAT_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic [AW:0]       rptr_d;
  logic [AW:0]       count;
  logic [BEAT_W-1:0] head_q;
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  assign count   = wptr_q - rptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && (count != '0);
  assign rptr_d  = rptr_q + (AW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // The head slot can only coincide with the write slot when the FIFO is
  // about to hold exactly the beat being written, so forward it directly.
  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + 1'b1;
      end
      rptr_q <= rptr_d;
      if (push_ok && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
        head_q <= wdata_i;
      end else begin
        head_q <= mem_q[rptr_d[AW-1:0]];
      end
    end
  end

  assign rdata_o = head_q;
  assign valid_o = (count != '0);
  assign count_o = count;

endmodule

// File: rtl/ase_pcie_ss_multi_chan_bridge.sv
// Multi-channel bridge between the ASE DPI-C tagged beat stream and NUM_CHANNELS
// pcie_ss AXI-S port pairs: per-channel RX FIFOs and a packet-atomic RR TX merge.
module ase_pcie_ss_multi_chan_bridge
  import ase_pcie_ss_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int DEPTH        = 8,
  parameter int TDATA_WIDTH  = 512,
  parameter int TUSER_WIDTH  = 10,
  localparam int CH_W        = ch_w(NUM_CHANNELS),
  localparam int BEAT_W      = beat_w(TDATA_WIDTH, TUSER_WIDTH)
) (
  input  logic                           pClk,
  input  logic                           SoftReset,
  input  logic                           h2a_valid,
  input  logic [CH_W-1:0]                h2a_chan,
  input  logic [BEAT_W-1:0]              h2a_beat,
  output logic [NUM_CHANNELS-1:0]        h2a_ready,
  output logic                           h2a_err,
  output logic [NUM_CHANNELS-1:0]        rx_tvalid,
  input  logic [NUM_CHANNELS-1:0]        rx_tready,
  output logic [NUM_CHANNELS*BEAT_W-1:0] rx_beat,
  input  logic [NUM_CHANNELS-1:0]        tx_tvalid,
  output logic [NUM_CHANNELS-1:0]        tx_tready,
  input  logic [NUM_CHANNELS*BEAT_W-1:0] tx_beat,
  output logic                           a2h_valid,
  input  logic                           a2h_ready,
  output logic [CH_W-1:0]                a2h_chan,
  output logic [BEAT_W-1:0]              a2h_beat
);

  localparam int CW = $clog2(DEPTH) + 1;

  // ---------------- Host -> AFU ----------------
  logic chan_bad;
  logic h2a_err_q;

  assign chan_bad = ({1'b0, h2a_chan} >= (CH_W+1)'(NUM_CHANNELS));

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic          push;
    logic          pop;
    logic [CW-1:0] count;

    assign push = h2a_valid && (h2a_chan == CH_W'(gi));
    assign pop  = rx_tvalid[gi] && rx_tready[gi];

    ase_pcie_ss_beat_fifo #(
      .DEPTH  (DEPTH),
      .BEAT_W (BEAT_W)
    ) u_fifo (
      .clk     (pClk),
      .srst    (SoftReset),
      .push_i  (push),
      .wdata_i (h2a_beat),
      .pop_i   (pop),
      .rdata_o (rx_beat[gi*BEAT_W +: BEAT_W]),
      .valid_o (rx_tvalid[gi]),
      .count_o (count)
    );

    assign h2a_ready[gi] = (count != CW'(DEPTH));
  end

  // Misrouted beats are swallowed; the flag stays up until the next reset.
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      h2a_err_q <= 1'b0;
    end else if (h2a_valid && chan_bad) begin
      h2a_err_q <= 1'b1;
    end
  end

  assign h2a_err = h2a_err_q;

  // ---------------- AFU -> host ----------------
  t_arb_state        state_q;
  logic [CH_W-1:0]   gnt_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic              a2h_valid_q;
  logic [CH_W-1:0]   a2h_chan_q;
  logic [BEAT_W-1:0] a2h_beat_q;

  logic [CH_W-1:0]   sel;
  logic              sel_found;
  logic [BEAT_W-1:0] sel_beat;
  logic              sel_last;
  logic              out_free;
  logic              xfer;
  logic [CH_W-1:0]   rr_next;

  // In IDLE the grant is combinational so a waiting channel moves a beat in
  // the very cycle it wins; lowest offset from rr_ptr_q wins.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = gnt_q;
    sel_found = (state_q == ARB_LOCKED);
    if (state_q == ARB_IDLE) begin
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
        idx = (int'(rr_ptr_q) + i) % NUM_CHANNELS;
        if (tx_tvalid[CH_W'(idx)]) begin
          sel       = CH_W'(idx);
          sel_found = 1'b1;
        end
      end
    end
  end

  assign sel_beat = tx_beat[int'(sel)*BEAT_W +: BEAT_W];
  assign sel_last = sel_beat[BEAT_W-1];
  assign out_free = !a2h_valid_q || a2h_ready;
  assign rr_next  = CH_W'((int'(sel) + 1) % NUM_CHANNELS);

  always_comb begin
    tx_tready = '0;
    if (!SoftReset && sel_found && out_free) begin
      tx_tready[sel] = 1'b1;
    end
  end

  assign xfer = tx_tready[sel] && tx_tvalid[sel];

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      a2h_valid_q <= 1'b0;
      a2h_chan_q  <= '0;
      a2h_beat_q  <= '0;
    end else begin
      if (xfer) begin
        a2h_valid_q <= 1'b1;
        a2h_chan_q  <= sel;
        a2h_beat_q  <= sel_beat;
      end else if (a2h_ready) begin
        a2h_valid_q <= 1'b0;
      end
      if (sel_found) begin
        gnt_q <= sel;
        if (xfer && sel_last) begin
          state_q  <= ARB_IDLE;
          rr_ptr_q <= rr_next;
        end else begin
          state_q <= ARB_LOCKED;
        end
      end
    end
  end

  assign a2h_valid = a2h_valid_q;
  assign a2h_chan  = a2h_chan_q;
  assign a2h_beat  = a2h_beat_q;

endmodule
